// File: rtl/axilite_noc_txn_scheduler.sv
// Shares one NoC request encoder between AXI-Lite reads and writes, one request at a time, with credit limit.
// Optional build macro AXILITE_NOC_SCHED_RR_EN: round-robin arbitration (default: writes win over reads).
module axilite_noc_txn_scheduler #(
    parameter int AXILITE_ADDR_WIDTH = 64,
    parameter int AXILITE_DATA_WIDTH = 64,
    parameter int MAX_OUTSTANDING    = 16,
    localparam int CNT_W  = $clog2(MAX_OUTSTANDING + 1),
    localparam int STRB_W = AXILITE_DATA_WIDTH / 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [AXILITE_ADDR_WIDTH-1:0] s_axi_araddr,
    input  logic                          s_axi_arvalid,
    output logic                          s_axi_arready,
    input  logic [AXILITE_ADDR_WIDTH-1:0] s_axi_awaddr,
    input  logic                          s_axi_awvalid,
    output logic                          s_axi_awready,
    input  logic [AXILITE_DATA_WIDTH-1:0] s_axi_wdata,
    input  logic [STRB_W-1:0]             s_axi_wstrb,
    input  logic                          s_axi_wvalid,
    output logic                          s_axi_wready,
    output logic                          req_valid,
    input  logic                          req_ready,
    output logic                          req_is_store,
    output logic [AXILITE_ADDR_WIDTH-1:0] req_addr,
    output logic [AXILITE_DATA_WIDTH-1:0] req_data,
    output logic [STRB_W-1:0]             req_strb,
    output logic                          transaction_type_wr,
    output logic [5:0]                    transaction_type_wr_data,
    input  logic                          transaction_fifo_full,
    input  logic                          rsp_read_done,
    input  logic                          rsp_write_done,
    output logic [CNT_W-1:0]              outstanding_cnt
);

    typedef enum logic {IDLE, ISSUE} state_t;

    state_t                          state_q, state_d;
    logic                            is_store_q;
    logic [AXILITE_ADDR_WIDTH-1:0]   addr_q;
    logic [AXILITE_DATA_WIDTH-1:0]   data_q;
    logic [STRB_W-1:0]               strb_q;
    logic [CNT_W-1:0]                cnt_q, cnt_d;
    logic                            grant_rd, grant_wr;
    logic                            can_accept, rd_cand, wr_cand;
    logic                            issue_hs, underflow;
    logic [1:0]                      dec_amt;
    logic [CNT_W:0]                  cnt_sum;
`ifdef AXILITE_NOC_SCHED_RR_EN
    logic                            prefer_wr_q, prefer_wr_d;
`endif

    assign rd_cand    = s_axi_arvalid;
    // AW and W are only ever taken together, so a write is a candidate only when both are valid.
    assign wr_cand    = s_axi_awvalid && s_axi_wvalid;
    assign can_accept = !transaction_fifo_full && (cnt_q < CNT_W'(MAX_OUTSTANDING));
    assign issue_hs   = req_valid && req_ready;

    always_comb begin
        state_d  = state_q;
        grant_rd = 1'b0;
        grant_wr = 1'b0;
`ifdef AXILITE_NOC_SCHED_RR_EN
        prefer_wr_d = prefer_wr_q;
`endif
        case (state_q)
            IDLE: begin
                if (!rst && can_accept) begin
`ifdef AXILITE_NOC_SCHED_RR_EN
                    if (rd_cand && wr_cand) begin
                        grant_wr = prefer_wr_q;
                        grant_rd = !prefer_wr_q;
                    end else begin
                        grant_wr = wr_cand;
                        grant_rd = rd_cand;
                    end
                    if (grant_rd || grant_wr) prefer_wr_d = grant_rd;
`else
                    grant_wr = wr_cand;
                    grant_rd = rd_cand && !wr_cand;
`endif
                    if (grant_rd || grant_wr) state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (issue_hs) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign s_axi_arready = grant_rd;
    assign s_axi_awready = grant_wr;
    assign s_axi_wready  = grant_wr;

    // Gating with rst drops a held request without a type push if reset lands mid-ISSUE.
    assign req_valid           = (state_q == ISSUE) && !rst;
    assign transaction_type_wr = issue_hs;
    assign req_is_store        = is_store_q;
    assign req_addr            = addr_q;
    assign req_data            = data_q;
    assign req_strb            = strb_q;
    assign transaction_type_wr_data = is_store_q ? {1'b1, 1'b0, 1'b0, addr_q[3], 2'b10}
                                                 : {1'b0, 1'b1, 1'b0, addr_q[3], 2'b01};

    // Both response classes may complete in one cycle, so the decrement can be two.
    assign dec_amt   = {1'b0, rsp_read_done} + {1'b0, rsp_write_done};
    assign cnt_sum   = {1'b0, cnt_q} + {{CNT_W{1'b0}}, issue_hs};
    assign underflow = cnt_sum < {{(CNT_W-1){1'b0}}, dec_amt};
    assign cnt_d     = underflow ? '0 : CNT_W'(cnt_sum - {{(CNT_W-1){1'b0}}, dec_amt});
    assign outstanding_cnt = cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            is_store_q <= 1'b0;
            addr_q     <= '0;
            data_q     <= '0;
            strb_q     <= '0;
            cnt_q      <= '0;
`ifdef AXILITE_NOC_SCHED_RR_EN
            prefer_wr_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
`ifdef AXILITE_NOC_SCHED_RR_EN
            prefer_wr_q <= prefer_wr_d;
`endif
            if (grant_rd) begin
                is_store_q <= 1'b0;
                addr_q     <= s_axi_araddr;
                data_q     <= '0;
                strb_q     <= '0;
            end else if (grant_wr) begin
                is_store_q <= 1'b1;
                addr_q     <= s_axi_awaddr;
                data_q     <= s_axi_wdata;
                strb_q     <= s_axi_wstrb;
            end
        end
    end

    credit_underflow_a : assert property (@(posedge clk) disable iff (rst) !underflow);

endmodule
